// File: rtl/ps_serializer_p_s.sv
// rtl/ps_serializer_p_s.sv - parallel-to-serial trigger serializer with handshake load, abort and back-to-back frames
module ps_serializer_p_s #(
    parameter int WIDTH      = 100,
    parameter int CNT_W      = 8,
    parameter int CLK_DIV    = 1,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    output logic             data_out,
    output logic             frame,
    output logic             bit_strobe,
    output logic             done,
    output logic             busy
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(CLK_DIV - 1);
    localparam int               OUT_BIT  = MSB_FIRST ? WIDTH - 1 : 0;

    state_t           state, n_state;
    logic [WIDTH-1:0] shreg, n_shreg;
    logic [CNT_W-1:0] bit_idx, n_bit_idx;
    logic [CNT_W-1:0] div_cnt, n_div_cnt;
    logic             accept;

    // done is registered and marks the last clock of the frame, so a new word
    // can be taken on that cycle without an idle gap.
    assign load_ready = !rst && !abort && (state == IDLE || done);
    assign accept     = load_valid && load_ready;

    always_comb begin
        n_state   = state;
        n_shreg   = shreg;
        n_bit_idx = bit_idx;
        n_div_cnt = div_cnt;
        if (accept) begin
            n_state   = SHIFT;
            n_shreg   = data_in;
            n_bit_idx = '0;
            n_div_cnt = '0;
        end else if (abort) begin
            n_state   = IDLE;
            n_bit_idx = '0;
            n_div_cnt = '0;
        end else if (state == SHIFT) begin
            if (div_cnt == LAST_DIV) begin
                n_div_cnt = '0;
                if (bit_idx == LAST_BIT) begin
                    n_state   = IDLE;
                    n_bit_idx = '0;
                end else begin
                    n_bit_idx = bit_idx + CNT_W'(1);
                    n_shreg   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                end
            end else begin
                n_div_cnt = div_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are registered from the next-state values so they line up with
    // the bit currently held in the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            div_cnt    <= '0;
            data_out   <= IDLE_LEVEL;
            frame      <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= n_state;
            shreg      <= n_shreg;
            bit_idx    <= n_bit_idx;
            div_cnt    <= n_div_cnt;
            data_out   <= (n_state == SHIFT) ? n_shreg[OUT_BIT] : IDLE_LEVEL;
            frame      <= (n_state == SHIFT);
            busy       <= (n_state == SHIFT);
            bit_strobe <= (n_state == SHIFT) && (n_div_cnt == '0);
            done       <= (n_state == SHIFT) && (n_bit_idx == LAST_BIT) && (n_div_cnt == LAST_DIV);
        end
    end
endmodule
